// File: rtl/pixel_fetch_if.sv
// rtl/pixel_fetch_if.sv - bus bundle between pixel_fetch, timing controller, frame buffer and DAC
//
// Purpose : groups the raster position, frame controls, memory read port and
//           colour outputs of the pixel fetch stage.
// Ports   : master = pixel_fetch side, slave = surrounding system side.
//   hcount, vcount      raster position from the timing controller
//   img_sel, fmt        requested image / format (latched once per frame)
//   pixel               memory read data
//   adr, rd_en          memory read address and strobe
//   pixel_r/g/b         8-bit colour to the video DAC
//   frame_start         one-cycle pulse on frame latch
//   img_cur             image currently displayed
interface pixel_fetch_if #(
  parameter int ADDR_W = 32,
  parameter int PIX_W  = 9,
  parameter int SEL_W  = 1
) ();
  logic [9:0]        hcount;
  logic [9:0]        vcount;
  logic [SEL_W-1:0]  img_sel;
  logic              fmt;
  logic [PIX_W-1:0]  pixel;
  logic [ADDR_W-1:0] adr;
  logic              rd_en;
  logic [7:0]        pixel_r;
  logic [7:0]        pixel_g;
  logic [7:0]        pixel_b;
  logic              frame_start;
  logic [SEL_W-1:0]  img_cur;

  modport master (
    input  hcount, vcount, img_sel, fmt, pixel,
    output adr, rd_en, pixel_r, pixel_g, pixel_b, frame_start, img_cur
  );

  modport slave (
    output hcount, vcount, img_sel, fmt, pixel,
    input  adr, rd_en, pixel_r, pixel_g, pixel_b, frame_start, img_cur
  );
endinterface

// File: rtl/pixel_fetch.sv
// rtl/pixel_fetch.sv - frame-buffer pixel fetch with latency compensation and colour expansion
//
// Purpose : issues one read per active raster position into the selected
//           image buffer, delays an active flag to meet the returned data and
//           expands the byte to 8-bit R/G/B (grayscale or RGB332). Image and
//           format are latched on the first blank line so frames never tear.
// Ports   :
//   clk     system clock, rising edge
//   rst_n   asynchronous active-low reset
//   bus     pixel_fetch_if.master (raster in, memory port, colour out)
// Latency : raster position at cycle t -> adr/rd_en at t+1 -> colour at
//           t+2+RD_LATENCY.
module pixel_fetch #(
  parameter int                H_ACTIVE     = 640,
  parameter int                V_ACTIVE     = 480,
  parameter int                ADDR_W       = 32,
  parameter int                PIX_W        = 9,
  parameter int                NUM_IMAGES   = 2,
  parameter logic [ADDR_W-1:0] BASE_ADDR    = '0,
  parameter logic [ADDR_W-1:0] IMAGE_STRIDE = ADDR_W'(307210),
  parameter int                RD_LATENCY   = 1,
  localparam int               SEL_W        = (NUM_IMAGES > 1) ? $clog2(NUM_IMAGES) : 1
) (
  input logic            clk,
  input logic            rst_n,
  pixel_fetch_if.master  bus
);

  localparam logic [10:0] H_LIM = 11'(H_ACTIVE);
  localparam logic [10:0] V_LIM = 11'(V_ACTIVE);

  logic [ADDR_W-1:0]   r_adr;
  logic                r_rd_en;
  logic [7:0]          r_pixel_r;
  logic [7:0]          r_pixel_g;
  logic [7:0]          r_pixel_b;
  logic                r_frame_start;
  logic [SEL_W-1:0]    r_img_cur;
  logic                r_fmt_cur;
  logic [ADDR_W-1:0]   r_img_base;
  // Active flag and its format travel together so in-flight pixels keep
  // the format they were fetched under even if a latch happens meanwhile.
  logic [RD_LATENCY:0] r_act;
  logic [RD_LATENCY:0] r_fmt_pipe;

  logic                w_active;
  logic                w_latch;
  logic [SEL_W-1:0]    w_img_next;
  logic [ADDR_W-1:0]   w_base_next;
  logic [ADDR_W-1:0]   w_addr;
  logic [7:0]          w_p;
  logic [7:0]          w_r;
  logic [7:0]          w_g;
  logic [7:0]          w_b;
  logic                w_unused_pix;

  // Anything at or beyond the active limits (including 1023) is blank.
  assign w_active = ({1'b0, bus.hcount} < H_LIM) && ({1'b0, bus.vcount} < V_LIM);
  assign w_latch  = ({1'b0, bus.vcount} == V_LIM) && (bus.hcount == 10'd0);

  // Out-of-range selections fall back to image 0.
  assign w_img_next  = (32'(bus.img_sel) < 32'(NUM_IMAGES)) ? bus.img_sel : '0;
  assign w_base_next = BASE_ADDR + ADDR_W'(w_img_next) * IMAGE_STRIDE;
  assign w_addr      = r_img_base + ADDR_W'(bus.vcount) * ADDR_W'(H_ACTIVE)
                     + ADDR_W'(bus.hcount);

  assign w_p          = bus.pixel[7:0];
  assign w_unused_pix = ^bus.pixel;

  always_comb begin
    w_r = w_p;
    w_g = w_p;
    w_b = w_p;
    if (r_fmt_pipe[RD_LATENCY]) begin
      // RGB332: replicate each field's MSBs to fill 8 bits.
      w_r = {w_p[7:5], w_p[7:5], w_p[7:6]};
      w_g = {w_p[4:2], w_p[4:2], w_p[4:3]};
      w_b = {w_p[1:0], w_p[1:0], w_p[1:0], w_p[1:0]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_adr         <= '0;
      r_rd_en       <= 1'b0;
      r_pixel_r     <= 8'h00;
      r_pixel_g     <= 8'h00;
      r_pixel_b     <= 8'h00;
      r_frame_start <= 1'b0;
      r_img_cur     <= '0;
      r_fmt_cur     <= 1'b0;
      r_img_base    <= BASE_ADDR;
      r_act         <= '0;
      r_fmt_pipe    <= '0;
    end else begin
      r_frame_start <= w_latch;
      if (w_latch) begin
        r_img_cur  <= w_img_next;
        r_fmt_cur  <= bus.fmt;
        r_img_base <= w_base_next;
      end

      // Address holds its last value through blanking.
      r_rd_en <= w_active;
      if (w_active) begin
        r_adr <= w_addr;
      end

      r_act      <= {r_act[RD_LATENCY-1:0], w_active};
      r_fmt_pipe <= {r_fmt_pipe[RD_LATENCY-1:0], r_fmt_cur};

      // Last flag stage lines up with the memory data of the same pixel.
      if (r_act[RD_LATENCY]) begin
        r_pixel_r <= w_r;
        r_pixel_g <= w_g;
        r_pixel_b <= w_b;
      end else begin
        r_pixel_r <= 8'h00;
        r_pixel_g <= 8'h00;
        r_pixel_b <= 8'h00;
      end
    end
  end

  assign bus.adr         = r_adr;
  assign bus.rd_en       = r_rd_en;
  assign bus.pixel_r     = r_pixel_r;
  assign bus.pixel_g     = r_pixel_g;
  assign bus.pixel_b     = r_pixel_b;
  assign bus.frame_start = r_frame_start;
  assign bus.img_cur     = r_img_cur;

endmodule

// File: tb/tb_pixel_fetch.sv
// tb/tb_pixel_fetch.sv - directed self-checking bench for pixel_fetch
module tb_pixel_fetch;

  logic clk = 1'b0;
  logic rst_n;
  int   n_pass = 0;
  int   n_chk  = 0;

  always #5 clk = ~clk;

  // b1: RD_LATENCY 1, 2 images, base 0. b3: RD_LATENCY 3, 3 images, base 0x100.
  pixel_fetch_if #(.ADDR_W(32), .PIX_W(9), .SEL_W(1)) b1 ();
  pixel_fetch_if #(.ADDR_W(32), .PIX_W(9), .SEL_W(2)) b3 ();

  assign b3.hcount = b1.hcount;
  assign b3.vcount = b1.vcount;
  assign b3.fmt    = b1.fmt;
  assign b3.pixel  = b1.pixel;

  pixel_fetch #(.RD_LATENCY(1)) u_l1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b1.master)
  );

  pixel_fetch #(.NUM_IMAGES(3), .BASE_ADDR(32'h100), .RD_LATENCY(3)) u_l3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b3.master)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input logic [9:0] h, input logic [9:0] v);
    b1.hcount = h;
    b1.vcount = v;
  endtask

  task automatic blanks(input int n);
    apply(10'd1023, 10'd1023);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    b1.img_sel = 1'b0;
    b3.img_sel = 2'd0;
    b1.fmt = 1'b0;
    b1.pixel = 9'h0AB;
    apply(10'd0, 10'd0);
    tick(); tick();
    n_chk++; if (b1.adr !== 32'd0) $display("FAIL rst_adr1 got %0h exp 0", b1.adr); else n_pass++;
    n_chk++; if (b1.rd_en !== 1'b0) $display("FAIL rst_rd_en1 got %b exp 0", b1.rd_en); else n_pass++;
    n_chk++; if ({b1.pixel_r, b1.pixel_g, b1.pixel_b} !== 24'h0) $display("FAIL rst_rgb1 got %h exp 000000", {b1.pixel_r, b1.pixel_g, b1.pixel_b}); else n_pass++;
    n_chk++; if (b1.frame_start !== 1'b0) $display("FAIL rst_fs1 got %b exp 0", b1.frame_start); else n_pass++;
    n_chk++; if (b1.img_cur !== 1'b0) $display("FAIL rst_img1 got %0d exp 0", b1.img_cur); else n_pass++;
    n_chk++; if (b3.adr !== 32'd0) $display("FAIL rst_adr3 got %0h exp 0", b3.adr); else n_pass++;
    n_chk++; if ({b3.pixel_r, b3.pixel_g, b3.pixel_b} !== 24'h0) $display("FAIL rst_rgb3 got %h exp 000000", {b3.pixel_r, b3.pixel_g, b3.pixel_b}); else n_pass++;
    apply(10'd1023, 10'd1023);
    rst_n = 1'b1;
    blanks(4);
  endtask

  task automatic test_scan();
    b1.pixel = 9'h0AB;
    apply(10'd0, 10'd0);     tick();   // E1
    n_chk++; if (b1.adr !== 32'd0) $display("FAIL scan_adr00 got %0d exp 0", b1.adr); else n_pass++;
    n_chk++; if (b1.rd_en !== 1'b1) $display("FAIL scan_rd_en got %b exp 1", b1.rd_en); else n_pass++;
    n_chk++; if (b3.adr !== 32'd256) $display("FAIL scan_adr00_b3 got %0d exp 256", b3.adr); else n_pass++;
    apply(10'd1, 10'd0);     tick();   // E2
    n_chk++; if (b1.adr !== 32'd1) $display("FAIL scan_adr10 got %0d exp 1", b1.adr); else n_pass++;
    n_chk++; if (b1.pixel_r !== 8'h00) $display("FAIL scan_early_r got %h exp 00", b1.pixel_r); else n_pass++;
    apply(10'd639, 10'd479); tick();   // E3
    n_chk++; if (b1.adr !== 32'd307199) $display("FAIL scan_adr_last got %0d exp 307199", b1.adr); else n_pass++;
    n_chk++; if ({b1.pixel_r, b1.pixel_g, b1.pixel_b} !== 24'hABABAB) $display("FAIL scan_gray_rgb got %h exp ababab", {b1.pixel_r, b1.pixel_g, b1.pixel_b}); else n_pass++;
    apply(10'd640, 10'd479); tick();   // E4
    n_chk++; if (b1.rd_en !== 1'b0) $display("FAIL scan_blank_rd_en got %b exp 0", b1.rd_en); else n_pass++;
    n_chk++; if (b1.adr !== 32'd307199) $display("FAIL scan_adr_hold got %0d exp 307199", b1.adr); else n_pass++;
    n_chk++; if (b3.pixel_r !== 8'h00) $display("FAIL scan_l3_early got %h exp 00", b3.pixel_r); else n_pass++;
    tick();                            // E5
    n_chk++; if (b3.pixel_g !== 8'hAB) $display("FAIL scan_l3_gray got %h exp ab", b3.pixel_g); else n_pass++;
    tick();                            // E6
    n_chk++; if (b1.pixel_r !== 8'h00) $display("FAIL scan_blank_r got %h exp 00", b1.pixel_r); else n_pass++;
    blanks(6);
  endtask

  task automatic test_frame_switch();
    b1.img_sel = 1'b1;
    b3.img_sel = 2'd2;
    apply(10'd5, 10'd10);   tick();
    n_chk++; if (b1.adr !== 32'd6405) $display("FAIL sw_midframe_adr got %0d exp 6405", b1.adr); else n_pass++;
    n_chk++; if (b1.img_cur !== 1'b0) $display("FAIL sw_midframe_img got %0d exp 0", b1.img_cur); else n_pass++;
    apply(10'd0, 10'd480);  tick();
    n_chk++; if (b1.frame_start !== 1'b1) $display("FAIL sw_fs got %b exp 1", b1.frame_start); else n_pass++;
    n_chk++; if (b1.img_cur !== 1'b1) $display("FAIL sw_img1 got %0d exp 1", b1.img_cur); else n_pass++;
    n_chk++; if (b3.img_cur !== 2'd2) $display("FAIL sw_img3 got %0d exp 2", b3.img_cur); else n_pass++;
    apply(10'd1, 10'd480);  tick();
    n_chk++; if (b1.frame_start !== 1'b0) $display("FAIL sw_fs_pulse got %b exp 0", b1.frame_start); else n_pass++;
    apply(10'd0, 10'd0);    tick();
    n_chk++; if (b1.adr !== 32'd307210) $display("FAIL sw_base1 got %0d exp 307210", b1.adr); else n_pass++;
    n_chk++; if (b3.adr !== 32'd614676) $display("FAIL sw_base3 got %0d exp 614676", b3.adr); else n_pass++;
    blanks(6);
  endtask

  task automatic test_rgb332();
    b1.fmt = 1'b1;
    b1.pixel = 9'h0E3;
    apply(10'd639, 10'd479); tick();   // E1: flag enters under grayscale
    apply(10'd0, 10'd480);   tick();   // E2: latch fmt=1
    apply(10'd1, 10'd480);   tick();   // E3
    n_chk++; if (b1.pixel_g !== 8'hE3) $display("FAIL fmt_inflight_l1 got %h exp e3", b1.pixel_g); else n_pass++;
    apply(10'd2, 10'd0);     tick();   // E4
    n_chk++; if (b1.adr !== 32'd307212) $display("FAIL fmt_adr got %0d exp 307212", b1.adr); else n_pass++;
    apply(10'd700, 10'd0);   tick();   // E5
    n_chk++; if (b3.pixel_g !== 8'hE3) $display("FAIL fmt_inflight_l3 got %h exp e3", b3.pixel_g); else n_pass++;
    tick();                            // E6
    n_chk++; if ({b1.pixel_r, b1.pixel_g, b1.pixel_b} !== 24'hFF00FF) $display("FAIL rgb332_e3 got %h exp ff00ff", {b1.pixel_r, b1.pixel_g, b1.pixel_b}); else n_pass++;
    blanks(6);
    b1.pixel = 9'h049;
    apply(10'd3, 10'd0);     tick();
    apply(10'd700, 10'd0);   tick(); tick();
    n_chk++; if ({b1.pixel_r, b1.pixel_g, b1.pixel_b} !== 24'h494955) $display("FAIL rgb332_49 got %h exp 494955", {b1.pixel_r, b1.pixel_g, b1.pixel_b}); else n_pass++;
    blanks(6);
  endtask

  task automatic test_blank_latency();
    b1.pixel = 9'h0FF;
    blanks(4);
    apply(10'd10, 10'd100);   tick();  // E1
    n_chk++; if (b1.adr !== 32'd371220) $display("FAIL bl_adr got %0d exp 371220", b1.adr); else n_pass++;
    apply(10'd640, 10'd100);  tick();  // E2
    n_chk++; if (b1.rd_en !== 1'b0) $display("FAIL bl_rd_en_h640 got %b exp 0", b1.rd_en); else n_pass++;
    n_chk++; if (b1.adr !== 32'd371220) $display("FAIL bl_adr_hold got %0d exp 371220", b1.adr); else n_pass++;
    n_chk++; if (b1.pixel_r !== 8'h00) $display("FAIL bl_l1_e2 got %h exp 00", b1.pixel_r); else n_pass++;
    apply(10'd5, 10'd1023);   tick();  // E3
    n_chk++; if (b1.rd_en !== 1'b0) $display("FAIL bl_rd_en_v1023 got %b exp 0", b1.rd_en); else n_pass++;
    n_chk++; if ({b1.pixel_r, b1.pixel_g, b1.pixel_b} !== 24'hFFFFFF) $display("FAIL bl_l1_e3 got %h exp ffffff", {b1.pixel_r, b1.pixel_g, b1.pixel_b}); else n_pass++;
    apply(10'd1023, 10'd0);   tick();  // E4
    n_chk++; if ({b1.pixel_r, b1.pixel_g, b1.pixel_b} !== 24'h0) $display("FAIL bl_l1_e4 got %h exp 000000", {b1.pixel_r, b1.pixel_g, b1.pixel_b}); else n_pass++;
    n_chk++; if (b3.pixel_r !== 8'h00) $display("FAIL bl_l3_e4 got %h exp 00", b3.pixel_r); else n_pass++;
    n_chk++; if (b1.rd_en !== 1'b0) $display("FAIL bl_rd_en_h1023 got %b exp 0", b1.rd_en); else n_pass++;
    tick();                            // E5
    n_chk++; if ({b3.pixel_r, b3.pixel_g, b3.pixel_b} !== 24'hFFFFFF) $display("FAIL bl_l3_e5 got %h exp ffffff", {b3.pixel_r, b3.pixel_g, b3.pixel_b}); else n_pass++;
    tick();                            // E6
    n_chk++; if (b3.pixel_b !== 8'h00) $display("FAIL bl_l3_e6 got %h exp 00", b3.pixel_b); else n_pass++;
    blanks(4);
  endtask

  task automatic test_bad_sel();
    b1.img_sel = 1'b0;
    b3.img_sel = 2'd3;
    b1.fmt = 1'b0;
    apply(10'd0, 10'd480); tick();
    n_chk++; if (b3.img_cur !== 2'd0) $display("FAIL sel3_img got %0d exp 0", b3.img_cur); else n_pass++;
    n_chk++; if (b3.frame_start !== 1'b1) $display("FAIL sel3_fs got %b exp 1", b3.frame_start); else n_pass++;
    n_chk++; if (b1.img_cur !== 1'b0) $display("FAIL sel0_img got %0d exp 0", b1.img_cur); else n_pass++;
    apply(10'd0, 10'd0);   tick();
    n_chk++; if (b3.adr !== 32'd256) $display("FAIL sel3_base got %0d exp 256", b3.adr); else n_pass++;
    n_chk++; if (b1.adr !== 32'd0) $display("FAIL sel0_base got %0d exp 0", b1.adr); else n_pass++;
    blanks(6);
  endtask

  task automatic test_reset_midline();
    b1.img_sel = 1'b1;
    b1.fmt = 1'b1;
    b1.pixel = 9'h0FF;
    apply(10'd0, 10'd480); tick();     // latch img 1 so reset has state to clear
    apply(10'd20, 10'd5);  tick();
    apply(10'd21, 10'd5);  tick();
    n_chk++; if (b1.img_cur !== 1'b1) $display("FAIL rm_pre_img got %0d exp 1", b1.img_cur); else n_pass++;
    apply(10'd1023, 10'd1023);
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if ({b1.pixel_r, b1.pixel_g, b1.pixel_b} !== 24'h0) $display("FAIL rm_rgb1 got %h exp 000000", {b1.pixel_r, b1.pixel_g, b1.pixel_b}); else n_pass++;
    n_chk++; if (b1.adr !== 32'd0) $display("FAIL rm_adr1 got %0d exp 0", b1.adr); else n_pass++;
    n_chk++; if (b1.rd_en !== 1'b0) $display("FAIL rm_rd_en got %b exp 0", b1.rd_en); else n_pass++;
    n_chk++; if (b1.img_cur !== 1'b0) $display("FAIL rm_img got %0d exp 0", b1.img_cur); else n_pass++;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_chk++; if ({b1.pixel_r, b3.pixel_r, b3.pixel_g, b3.pixel_b} !== 32'h0) $display("FAIL rm_stale cyc %0d got %h exp 00000000", i, {b1.pixel_r, b3.pixel_r, b3.pixel_g, b3.pixel_b}); else n_pass++;
    end
    apply(10'd0, 10'd0); tick();
    n_chk++; if (b1.adr !== 32'd0) $display("FAIL rm_base_after got %0d exp 0", b1.adr); else n_pass++;
    blanks(2);
  endtask

  initial begin
    test_reset();
    test_scan();
    test_frame_switch();
    test_rgb332();
    test_blank_latency();
    test_bad_sel();
    test_reset_midline();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
